// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronizes and debounces a raw button, emitting a registered level and one-cycle edge strobes
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic sync1, sync_q, level_n, rise_n, fall_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync_q <= 1'b0;
      state <= STABLE_LOW;
      cnt <= '0;
      level_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync_q <= sync1;
      state <= state_n;
      cnt <= cnt_n;
      level_out <= level_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end
  // cnt counts agreeing samples seen so far in a WAIT state; LAST means this sample completes the run
  always_comb begin
    state_n = state;
    cnt_n = '0;
    level_n = level_out;
    rise_n = 1'b0;
    fall_n = 1'b0;
    case (state)
      STABLE_LOW: if (sync_q) begin
        state_n = WAIT_HIGH;
        cnt_n = CNT_W'(1);
      end
      WAIT_HIGH: if (!sync_q) state_n = STABLE_LOW;
        else if (cnt == LAST) begin
          state_n = STABLE_HIGH;
          level_n = 1'b1;
          rise_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      STABLE_HIGH: if (!sync_q) begin
        state_n = WAIT_LOW;
        cnt_n = CNT_W'(1);
      end
      WAIT_LOW: if (sync_q) state_n = STABLE_HIGH;
        else if (cnt == LAST) begin
          state_n = STABLE_LOW;
          level_n = 1'b0;
          fall_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: state_n = STABLE_LOW;
    endcase
  end
endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: directed checks of debounce latency, glitch/bounce rejection, reset and a downstream toggle flop
module tb_debounce_pulse;
  logic clk = 1'b0, reset = 1'b0, btn_in = 1'b0;
  logic level_out, rise_pulse, fall_pulse;
  logic q_tff, q0;
  int checks = 0, failures = 0, rise_cnt = 0;

  debounce_pulse #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset)
    if (!reset) q_tff <= 1'b0;
    else if (rise_pulse) q_tff <= ~q_tff;

  always @(posedge clk) if (reset && rise_pulse) rise_cnt++;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic l, input logic r, input logic f);
    tick();
    chk({tag, ".level"}, level_out, l);
    chk({tag, ".rise"}, rise_pulse, r);
    chk({tag, ".fall"}, fall_pulse, f);
  endtask

  initial begin
    #1;
    chk("reset.level", level_out, 1'b0);
    chk("reset.rise", rise_pulse, 1'b0);
    chk("reset.fall", fall_pulse, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0);
    // clean press: strobe after E5, the sixth edge counting E0
    btn_in = 1'b1;
    repeat (5) step("press.wait", 1'b0, 1'b0, 1'b0);
    step("press.accept", 1'b1, 1'b1, 1'b0);
    repeat (5) step("press.hold", 1'b1, 1'b0, 1'b0);
    btn_in = 1'b0;
    repeat (5) step("release.wait", 1'b1, 1'b0, 1'b0);
    step("release.accept", 1'b0, 1'b0, 1'b1);
    repeat (3) step("release.hold", 1'b0, 1'b0, 1'b0);
    // glitch: two high samples only
    btn_in = 1'b1;
    tick();
    tick();
    btn_in = 1'b0;
    repeat (10) step("glitch", 1'b0, 1'b0, 1'b0);
    // bounce 1,0,1,0 then hold high
    for (int i = 0; i < 4; i++) begin
      btn_in = (i % 2 == 0);
      step("bounce", 1'b0, 1'b0, 1'b0);
    end
    btn_in = 1'b1;
    repeat (5) step("bounce.wait", 1'b0, 1'b0, 1'b0);
    step("bounce.accept", 1'b1, 1'b1, 1'b0);
    step("bounce.hold", 1'b1, 1'b0, 1'b0);
    btn_in = 1'b0;
    repeat (5) step("rel2.wait", 1'b1, 1'b0, 1'b0);
    step("rel2.accept", 1'b0, 1'b0, 1'b1);
    step("rel2.hold", 1'b0, 1'b0, 1'b0);
    // reset two edges into WAIT_HIGH
    btn_in = 1'b1;
    repeat (4) step("midwait.pre", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midwait.level", level_out, 1'b0);
    chk("midwait.rise", rise_pulse, 1'b0);
    repeat (2) step("midwait.held", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (5) step("postrst.wait", 1'b0, 1'b0, 1'b0);
    step("postrst.accept", 1'b1, 1'b1, 1'b0);
    step("postrst.hold", 1'b1, 1'b0, 1'b0);
    btn_in = 1'b0;
    repeat (8) tick();
    chk("tff.start_level", level_out, 1'b0);
    // downstream toggle flop over three press/release cycles
    q0 = q_tff;
    rise_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      btn_in = 1'b1;
      repeat (8) tick();
      btn_in = 1'b0;
      repeat (8) tick();
    end
    chk_int("tff.rises", rise_cnt, 3);
    chk("tff.q", q_tff, ~q0);
    // asynchronous reset while level is high, between clock edges
    btn_in = 1'b1;
    repeat (8) tick();
    chk("async.pre_level", level_out, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async.level", level_out, 1'b0);
    chk("async.rise", rise_pulse, 1'b0);
    chk("async.fall", fall_pulse, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
